// File: rtl/sorter_axil_pkg.sv
// Shared constants and types for the sorter AXI4-Lite peripherals.
// The read and write slaves both import this package.
package sorter_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] VAL_ADDR  = 8'h00;
  localparam logic [7:0] IVAL_ADDR = 8'h04;
  localparam logic [7:0] STAT_ADDR = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } rd_state_t;

endpackage

// File: rtl/sort_axil_rd_slave.sv
// AXI4-Lite read slave that pops the external val/ival FIFOs of the sorter.
// Optional status register at 0x08 is enabled by defining SORT_RD_STATUS_EN.
module sort_axil_rd_slave
  import sorter_axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int VAL_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              val_rd_en,
  output logic              ival_rd_en,
  input  logic [VAL_W-1:0]  val_dout,
  input  logic [VAL_W-1:0]  ival_dout,
  input  logic              val_empty,
  input  logic              ival_empty,
  input  logic              val_full,
  input  logic              ival_full,
  input  logic [7:0]        val_fifo_ctr,
  input  logic [7:0]        ival_fifo_ctr
);

  rd_state_t state_q, state_d;
  logic      sel_ival;
  logic      ar_hs;

  logic [7:0]        addr8;
  logic              is_val, is_ival;
  logic              pop_ok;
  logic [DATA_W-1:0] direct_data;
  logic [1:0]        direct_resp;
  logic [DATA_W-1:0] pop_data;

  assign addr8   = ARADDR[7:0];
  assign is_val  = (addr8 == VAL_ADDR);
  assign is_ival = (addr8 == IVAL_ADDR);
  assign pop_ok  = (is_val && !val_empty) || (is_ival && !ival_empty);

`ifdef SORT_RD_STATUS_EN
  logic [31:0] stat_word;
  assign stat_word = {ival_fifo_ctr, val_fifo_ctr, 12'h000,
                      ival_full, ival_empty, val_full, val_empty};

  logic unused_in;
  assign unused_in = ^ARADDR[ADDR_W-1:8];

  // Response for everything that does not pop: status, empty pop, unmapped
  always_comb begin
    direct_data = '0;
    direct_resp = RESP_SLVERR;
    if (addr8 == STAT_ADDR) begin
      direct_data = DATA_W'(stat_word);
      direct_resp = RESP_OKAY;
    end
  end
`else
  logic unused_in;
  assign unused_in = ^{ARADDR[ADDR_W-1:8], val_full, ival_full,
                       val_fifo_ctr, ival_fifo_ctr};

  // Response for everything that does not pop: empty pop or unmapped
  always_comb begin
    direct_data = '0;
    direct_resp = RESP_SLVERR;
  end
`endif

  // Place the popped FIFO word in the RDATA MSBs, rest zero
  always_comb begin
    pop_data = '0;
    pop_data[DATA_W-1 -: VAL_W] = sel_ival ? ival_dout : val_dout;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and handshake outputs; gated by rst so nothing is driven in reset
  always_comb begin
    state_d    = state_q;
    ARREADY    = 1'b0;
    RVALID     = 1'b0;
    val_rd_en  = 1'b0;
    ival_rd_en = 1'b0;
    ar_hs      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ARREADY = rst;
        if (ARVALID && rst) begin
          ar_hs   = 1'b1;
          state_d = pop_ok ? ST_POP : ST_RESP;
        end
      end
      ST_POP: begin
        val_rd_en  = rst && !sel_ival;
        ival_rd_en = rst && sel_ival;
        state_d    = ST_CAPT;
      end
      ST_CAPT: state_d = ST_RESP;
      ST_RESP: begin
        RVALID = rst;
        if (RREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers: formed at AR handshake for non-pops, captured in CAPT for pops
  always_ff @(posedge clk) begin
    if (!rst) begin
      RDATA    <= '0;
      RRESP    <= RESP_OKAY;
      sel_ival <= 1'b0;
    end else if (ar_hs) begin
      sel_ival <= is_ival;
      if (!pop_ok) begin
        RDATA <= direct_data;
        RRESP <= direct_resp;
      end
    end else if (state_q == ST_CAPT) begin
      RDATA <= pop_data;
      RRESP <= RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_sort_axil_rd_slave.sv
// Directed bench for sort_axil_rd_slave: table of single reads plus
// hand-written stall and mid-transaction reset sequences.
module tb_sort_axil_rd_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        val_rd_en, ival_rd_en;
  logic [7:0]  val_dout, ival_dout;
  logic        val_empty, ival_empty, val_full, ival_full;
  logic [7:0]  val_fifo_ctr, ival_fifo_ctr;

  logic [7:0]  val_word, ival_word;
  int          vpops = 0;
  int          ipops = 0;
  int          total = 0;
  int          bad   = 0;

  sort_axil_rd_slave #(.ADDR_W(32), .DATA_W(32), .VAL_W(8)) dut (
    .clk(clk), .rst(rst),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .val_rd_en(val_rd_en), .ival_rd_en(ival_rd_en),
    .val_dout(val_dout), .ival_dout(ival_dout),
    .val_empty(val_empty), .ival_empty(ival_empty),
    .val_full(val_full), .ival_full(ival_full),
    .val_fifo_ctr(val_fifo_ctr), .ival_fifo_ctr(ival_fifo_ctr)
  );

  always #5 clk = ~clk;

  // FIFO stand-in: dout valid the cycle after rd_en
  always @(posedge clk) begin
    if (val_rd_en) begin
      val_dout <= val_word;
      vpops++;
    end
    if (ival_rd_en) begin
      ival_dout <= ival_word;
      ipops++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one read; returns cycles from handshake to RVALID (0 on timeout)
  task automatic do_read(input logic [31:0] a, input logic rr, output int lat);
    @(negedge clk);
    chk("arready_idle", {31'b0, ARREADY}, 32'd1);
    ARADDR  = a;
    ARVALID = 1'b1;
    RREADY  = rr;
    @(posedge clk);
    #1 ARVALID = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (RVALID) begin
        lat = i;
        break;
      end
    end
  endtask

  // Complete the R handshake from a negedge where RVALID is high
  task automatic finish_resp();
    chk("arready_in_resp", {31'b0, ARREADY}, 32'd0);
    RREADY = 1'b1;
    @(posedge clk);
    #1 RREADY = 1'b0;
    @(negedge clk);
    chk("rvalid_after_r_hs", {31'b0, RVALID}, 32'd0);
    chk("arready_after_r_hs", {31'b0, ARREADY}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        v_empty;
    logic        i_empty;
    logic [7:0]  v_word;
    logic [7:0]  i_word;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_lat;
    int          exp_vp;
    int          exp_ip;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, vp0, ip0;
    logic [31:0] hold_data;

    vecs[0] = '{"pop_val",      32'h0000_0000, 1'b0, 1'b0, 8'hA5, 8'h11, 32'hA500_0000, 2'b00, 3, 1, 0};
    vecs[1] = '{"pop_ival",     32'h0000_0004, 1'b0, 1'b0, 8'h22, 8'h3C, 32'h3C00_0000, 2'b00, 3, 0, 1};
    vecs[2] = '{"ival_empty",   32'h0000_0004, 1'b0, 1'b1, 8'h33, 8'h44, 32'h0,         2'b10, 1, 0, 0};
    vecs[3] = '{"val_empty",    32'h0000_0000, 1'b1, 1'b0, 8'h55, 8'h66, 32'h0,         2'b10, 1, 0, 0};
    vecs[4] = '{"unmapped_0c",  32'h0000_000C, 1'b0, 1'b0, 8'h77, 8'h88, 32'h0,         2'b10, 1, 0, 0};
`ifdef SORT_RD_STATUS_EN
    vecs[5] = '{"status",       32'h0000_0008, 1'b0, 1'b1, 8'h99, 8'hAA, 32'h0003_0004, 2'b00, 1, 0, 0};
`else
    vecs[5] = '{"status",       32'h0000_0008, 1'b0, 1'b1, 8'h99, 8'hAA, 32'h0,         2'b10, 1, 0, 0};
`endif
    vecs[6] = '{"upper_ignored", 32'hFFFF_FF00, 1'b0, 1'b0, 8'h5A, 8'hBB, 32'h5A00_0000, 2'b00, 3, 1, 0};
    vecs[7] = '{"unmapped_01",  32'h0000_0001, 1'b0, 1'b0, 8'hCC, 8'hDD, 32'h0,         2'b10, 1, 0, 0};

    rst = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    val_empty = 1'b0; ival_empty = 1'b0; val_full = 1'b0; ival_full = 1'b0;
    val_fifo_ctr = 8'd3; ival_fifo_ctr = 8'd0;
    val_word = 8'h00; ival_word = 8'h00; val_dout = 8'h00; ival_dout = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", {31'b0, ARREADY}, 32'd0);
    chk("rst_rvalid", {31'b0, RVALID}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_rresp", {30'b0, RRESP}, 32'd0);
    chk("rst_rd_en", {30'b0, val_rd_en, ival_rd_en}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      val_empty  = vecs[i].v_empty;
      ival_empty = vecs[i].i_empty;
      val_word   = vecs[i].v_word;
      ival_word  = vecs[i].i_word;
      vp0 = vpops; ip0 = ipops;
      do_read(vecs[i].addr, 1'b0, lat);
      chk({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_rdata"}, RDATA, vecs[i].exp_data);
      chk({vecs[i].name, "_rresp"}, {30'b0, RRESP}, {30'b0, vecs[i].exp_resp});
      chk({vecs[i].name, "_vpops"}, vpops - vp0, vecs[i].exp_vp);
      chk({vecs[i].name, "_ipops"}, ipops - ip0, vecs[i].exp_ip);
      finish_resp();
    end

    // Stall: RREADY low for 5 cycles with RVALID up
    val_empty = 1'b0; ival_empty = 1'b0; val_word = 8'hE7;
    vp0 = vpops;
    do_read(32'h0, 1'b0, lat);
    chk("stall_lat", lat, 3);
    hold_data = RDATA;
    chk("stall_rdata", hold_data, 32'hE700_0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_rvalid", {31'b0, RVALID}, 32'd1);
      chk("stall_rdata_hold", RDATA, 32'hE700_0000);
      chk("stall_rresp_hold", {30'b0, RRESP}, 32'd0);
      chk("stall_arready", {31'b0, ARREADY}, 32'd0);
    end
    chk("stall_pops", vpops - vp0, 1);
    finish_resp();

    // Reset asserted while in CAPT aborts the read
    val_word = 8'h42;
    @(negedge clk);
    ARADDR = 32'h0; ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge clk);
    #1 ARVALID = 1'b0;
    @(negedge clk);              // POP
    @(negedge clk);              // CAPT
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rvalid", {31'b0, RVALID}, 32'd0);
    chk("rstmid_arready", {31'b0, ARREADY}, 32'd0);
    chk("rstmid_rd_en", {30'b0, val_rd_en, ival_rd_en}, 32'd0);
    rst = 1'b1;
    RREADY = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstrel_arready", {31'b0, ARREADY}, 32'd1);
    chk("rstrel_rvalid", {31'b0, RVALID}, 32'd0);

    val_word = 8'h96;
    vp0 = vpops;
    do_read(32'h0, 1'b0, lat);
    chk("after_rst_lat", lat, 3);
    chk("after_rst_rdata", RDATA, 32'h9600_0000);
    chk("after_rst_pops", vpops - vp0, 1);
    finish_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
